// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Holds the FSM state type, digit select codes and width helpers.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Magnitude of a Booth digit; the sign travels separately.
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_1X   = 2'd1;
    localparam logic [1:0] SEL_2X   = 2'd2;

    localparam int W_DEF = 8;
    localparam int PPW   = W_DEF + 2;
    localparam int ACCW  = 2 * W_DEF + 2;

    function automatic int pp_w(input int w);
        return w + 2;
    endfunction

    function automatic int acc_w(input int w);
        return 2 * w + 2;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Booth partial-product select: triplet + multiplicand -> W+2 bit pp.
// Ports: triplet[2:0], a[W-1:0] in; pp[W+1:0] (inverted if negative), cin out.
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   triplet,
    input  logic [W-1:0] a,
    output logic [W+1:0] pp,
    output logic         cin
);

    logic [1:0]   w_sel;
    logic         w_neg;
    logic [W+1:0] w_mag;

    always_comb begin
        w_sel = SEL_ZERO;
        unique case (triplet)
            3'b000, 3'b111: w_sel = SEL_ZERO;
            3'b001, 3'b010: w_sel = SEL_1X;
            3'b101, 3'b110: w_sel = SEL_1X;
            3'b011, 3'b100: w_sel = SEL_2X;
            default:        w_sel = SEL_ZERO;
        endcase
    end

    // 111 is a zero digit, so it must not set the negate flag.
    assign w_neg = triplet[2] & ~(&triplet[1:0]);

    always_comb begin
        w_mag = '0;
        case (w_sel)
            SEL_1X:  w_mag = {{2{a[W-1]}}, a};
            SEL_2X:  w_mag = {a[W-1], a, 1'b0};
            default: w_mag = '0;
        endcase
    end

    // Negation is ~mag plus a carry-in applied in the accumulator.
    assign pp  = w_neg ? ~w_mag : w_mag;
    assign cin = w_neg;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, start/done handshake.
// Ports: clk, rst (sync high), start, a, b in; busy, done, p[2W-1:0] out.
// Option: BOOTH_EARLY_TERM_EN ends RUN once all remaining digits are zero.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int LPW = pp_w(W);
    localparam int LAW = acc_w(W);
    localparam int IW  = (W / 2 > 1) ? $clog2(W / 2) : 1;
    localparam logic [IW-1:0] LAST = IW'(W / 2 - 1);

    state_e         r_state;
    logic [W-1:0]   r_a;
    // {b, b[-1]} shifted right two bits per iteration; [2:0] is the triplet.
    logic [W:0]     r_bs;
    logic [IW-1:0]  r_i;
    logic [LAW-1:0] r_acc;
    logic [2*W-1:0] r_p;

    logic [LPW-1:0] w_pp;
    logic           w_cin;
    logic [LAW-1:0] w_ppx;
    logic [LAW-1:0] w_acc_nxt;
    logic           w_term;

    booth_pp_sel #(.W(W)) u_pp_sel (
        .triplet (r_bs[2:0]),
        .a       (r_a),
        .pp      (w_pp),
        .cin     (w_cin)
    );

    always_comb begin
        w_ppx     = {{(LAW - LPW){w_pp[LPW-1]}}, w_pp};
        w_acc_nxt = r_acc
                  + (w_ppx << {r_i, 1'b0})
                  + (LAW'(w_cin) << {r_i, 1'b0});
    end

`ifdef BOOTH_EARLY_TERM_EN
    // r_bs sign-fills as it shifts, so it holds b[W-1:2i-1] plus copies
    // of the sign; uniform means every remaining digit is zero.
    assign w_term = (&r_bs) | ~(|r_bs);
`else
    assign w_term = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_bs    <= '0;
            r_i     <= '0;
            r_acc   <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_bs    <= {b, 1'b0};
                        r_i     <= '0;
                        r_acc   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_term) begin
                        r_p     <= r_acc[2*W-1:0];
                        r_state <= DONE;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_bs  <= {{2{r_bs[W]}}, r_bs[W:2]};
                        r_i   <= r_i + 1'b1;
                        if (r_i == LAST) begin
                            r_p     <= w_acc_nxt[2*W-1:0];
                            r_state <= DONE;
                        end
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign p    = r_p;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (W=8): vector table, corner
// sequences and a random sweep against plain signed multiplication.
module tb_booth_mul_seq;

    localparam int W = 8;
    localparam int LAT = W / 2 + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int total = 0;
    int bad   = 0;

    booth_mul_seq #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   va;
        logic [W-1:0]   vb;
        logic [2*W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) * int'($signed(y));
        return r[2*W-1:0];
    endfunction

    // Issue one multiply; returns product, edges to done (-1 on timeout),
    // count of not-busy cycles before done, and done level one cycle later.
    task automatic run_mul(input logic [W-1:0] ia, input logic [W-1:0] ib,
                           output logic [2*W-1:0] op, output int lat,
                           output int idle_cnt, output logic done_after);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        idle_cnt = 0;
        while (!done && lat < 40) begin
            if (!busy) idle_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        op = p;
        if (!done) lat = -1;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    initial begin
        vec_t vt[8];
        logic [2*W-1:0] rp;
        int lat;
        int idl;
        logic da;
        int dseen;
        int tmo;

        vt[0] = '{8'd7,   8'hFD, 16'hFFEB};
        vt[1] = '{8'h80,  8'h80, 16'h4000};
        vt[2] = '{8'h80,  8'h7F, 16'hC080};
        vt[3] = '{8'h55,  8'h00, 16'h0000};
        vt[4] = '{8'h00,  8'hFF, 16'h0000};
        vt[5] = '{8'h7F,  8'h7F, 16'h3F01};
        vt[6] = '{8'hFF,  8'hFF, 16'h0001};
        vt[7] = '{8'h01,  8'h80, 16'hFF80};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_p", longint'(p), 0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_mul(vt[k].va, vt[k].vb, rp, lat, idl, da);
            chk($sformatf("vec%0d_p", k), longint'(rp), longint'(vt[k].exp));
            chk($sformatf("vec%0d_busy", k), longint'(idl), 0);
            chk($sformatf("vec%0d_pulse", k), longint'(da), 0);
`ifdef BOOTH_EARLY_TERM_EN
            if (vt[k].vb == '0)
                chk($sformatf("vec%0d_lat", k), longint'(lat), 2);
`else
            chk($sformatf("vec%0d_lat", k), longint'(lat), LAT);
`endif
        end

        // start and operand changes during RUN must be ignored
        @(negedge clk);
        a = 8'd7;
        b = 8'hFD;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd100;
        b = 8'd100;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        tmo = 0;
        while (!done && tmo < 40) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        chk("ign_timeout", longint'(done), 1);
        chk("ign_p", longint'(p), 64'hFFEB);
        @(posedge clk);
        #1;

        // reset in the second RUN cycle aborts the multiply
        @(negedge clk);
        a = 8'h80;
        b = 8'h80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_p", longint'(p), 0);
        dseen = 0;
        repeat (6) begin
            if (done) dseen++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", longint'(dseen), 0);
        run_mul(8'hC3, 8'h5A, rp, lat, idl, da);
        chk("post_abort_p", longint'(rp), longint'(ref_mul(8'hC3, 8'h5A)));

        // random signed sweep
        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            run_mul(ra, rb, rp, lat, idl, da);
            chk($sformatf("rnd%0d_p", k), longint'(rp), longint'(ref_mul(ra, rb)));
`ifndef BOOTH_EARLY_TERM_EN
            chk($sformatf("rnd%0d_lat", k), longint'(lat), LAT);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
